// File: rtl/del_map_fuse.sv
// -----------------------------------------------------------------------------
// del_map_fuse
//
// Fuses two edge maps using the HSSIM decision stream. Each old/new edge-map
// beat enters a delay line at the same time as HSSIM sees it. When the beat
// reaches the tail of the delay line, its HSSIM del beat is on the del input.
// At that point each byte of the fused beat takes the new-map pixel when the
// MSB of the matching del byte is set, and the old-map pixel otherwise. The
// fused beat leaves on an AXI-Stream master port. tlast is set on the final
// beat of each frame.
//
// Back-pressure: stall = m_tvalid & ~m_tready. This signal freezes HSSIM, the
// upstream source and this block's delay line and output register, all
// together. Because everything freezes in lockstep, the tail beat and del
// stay aligned.
//
// Parameters
//   PIXELS_PER_BEAT  bytes (pixels) per beat
//   IMAGE_DIM        image width = height in pixels
//   HSSIM_LATENCY    non-stalled cycles from beat in to del out (>= 1)
//   DATA_WIDTH       beat width, 8*PIXELS_PER_BEAT
//
// Ports
//   clk        single clock
//   reset      synchronous, active-high; drops in-flight beats, restarts frame
//   s_valid    a valid beat is presented this cycle (held by source on stall)
//   old_map    old edge-map beat
//   new_map    new edge-map beat
//   del        HSSIM decision beat, per byte MSB: 1 = take new, 0 = keep old
//   stall      global freeze for HSSIM and upstream
//   m_tdata    fused beat
//   m_tvalid   m_tdata valid
//   m_tready   downstream accept
//   m_tlast    last beat of frame
//   new_count  (FUSE_STATS_EN only) number of new-map pixels selected in the
//              most recently completed frame
//
// Optional build macro
//   FUSE_STATS_EN  adds the new_count output and its per-frame accumulator.
// -----------------------------------------------------------------------------
module del_map_fuse #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int HSSIM_LATENCY   = 8,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
  // Derived width of new_count. Leave at its default.
  parameter int STAT_W          = $clog2(IMAGE_DIM * IMAGE_DIM) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] old_map,
  input  logic [DATA_WIDTH-1:0] new_map,
  input  logic [DATA_WIDTH-1:0] del,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
`ifdef FUSE_STATS_EN
  ,
  output logic [STAT_W-1:0]     new_count
`endif
);

  localparam int BEATS_PER_FRAME = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int CNT_W           = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);

  // ---------------------------------------------------------------------------
  // Global stall. Everything in this block advances only when it is low.
  // ---------------------------------------------------------------------------
  logic advance;

  assign stall   = m_tvalid & ~m_tready;
  assign advance = ~stall;

  // ---------------------------------------------------------------------------
  // Delay line: HSSIM_LATENCY stages of {vld, old, new}.
  // The valid bits are reset so that in-flight beats are discarded.
  // ---------------------------------------------------------------------------
  logic [HSSIM_LATENCY-1:0] dly_vld;
  logic [DATA_WIDTH-1:0]    dly_old [HSSIM_LATENCY];
  logic [DATA_WIDTH-1:0]    dly_new [HSSIM_LATENCY];

  // NOTE: sequential state uses <= so that every stage samples its
  // predecessor's value from before the edge, not the value just written.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_vld <= '0;
    end else if (advance) begin
      dly_vld[0] <= s_valid;
      for (int i = 1; i < HSSIM_LATENCY; i++) begin
        dly_vld[i] <= dly_vld[i-1];
      end
    end
  end

  // NOTE: the payload array has no reset. Only the valid bits decide whether a
  // stage holds a real beat, so stale data behind a cleared vld is harmless.
  // This also keeps the reset off the wide datapath.
  always_ff @(posedge clk) begin
    if (advance) begin
      dly_old[0] <= old_map;
      dly_new[0] <= new_map;
      for (int i = 1; i < HSSIM_LATENCY; i++) begin
        dly_old[i] <= dly_old[i-1];
        dly_new[i] <= dly_new[i-1];
      end
    end
  end

  logic                  tail_vld;
  logic [DATA_WIDTH-1:0] tail_old;
  logic [DATA_WIDTH-1:0] tail_new;

  assign tail_vld = dly_vld[HSSIM_LATENCY-1];
  assign tail_old = dly_old[HSSIM_LATENCY-1];
  assign tail_new = dly_new[HSSIM_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Per-byte select. Only the MSB of each del byte is decoded, so a
  // non-canonical decision byte resolves by its top bit alone.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fused;

  // NOTE: fused gets a default before the loop. Every path then assigns it,
  // so this stays purely combinational and no latch can be inferred.
  always_comb begin
    fused = '0;
    for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
      fused[j*8 +: 8] = del[j*8 + 7] ? tail_new[j*8 +: 8] : tail_old[j*8 +: 8];
    end
  end

  // Only the decision MSBs are decoded. The remaining del bits are folded into
  // this sink so the intent of leaving them unused is explicit.
  logic unused_del_bits;
  assign unused_del_bits = ^del;

  // ---------------------------------------------------------------------------
  // Frame position and output register.
  // A bubble at the tail clears m_tvalid but leaves m_tdata as it was. Under
  // stall, all of these registers hold, so a presented beat stays stable
  // until it is accepted.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] beat_cnt;
  logic             frame_end;

  assign frame_end = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      beat_cnt <= '0;
    end else if (advance) begin
      m_tvalid <= tail_vld;
      m_tlast  <= tail_vld & frame_end;
      if (tail_vld) begin
        m_tdata  <= fused;
        // Wrap explicitly so that frame sizes which are not a power of two
        // also restart at beat 0 with no gap.
        beat_cnt <= frame_end ? '0 : beat_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FUSE_STATS_EN
  // ---------------------------------------------------------------------------
  // Selection statistics: count the new-map pixels chosen in each frame.
  // Publish the total at the frame's tlast load, and hold it until the next
  // frame end.
  // ---------------------------------------------------------------------------
  logic [STAT_W-1:0] sel_count;
  logic [STAT_W-1:0] sel_accum;

  always_comb begin
    sel_count = '0;
    for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
      sel_count = sel_count + STAT_W'(del[j*8 + 7]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_accum <= '0;
      new_count <= '0;
    end else if (advance && tail_vld) begin
      if (frame_end) begin
        new_count <= sel_accum + sel_count;
        sel_accum <= '0;
      end else begin
        sel_accum <= sel_accum + sel_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_del_map_fuse.sv
// -----------------------------------------------------------------------------
// tb_del_map_fuse
//
// Directed bench for del_map_fuse at PIXELS_PER_BEAT=4, IMAGE_DIM=8,
// HSSIM_LATENCY=3 (16 beats per frame).
//
// A table of 16 {old, new, del, expected fused} records is filled in by hand.
// The source walks through the table one beat per frame position. A small
// HSSIM stand-in delays each beat's del by HSSIM_LATENCY non-stalled cycles.
// A scoreboard queue holds the expected {data, last} of every beat the DUT
// accepted, and the monitor pops one entry per handshake. Hand-written
// sequences cover the latency, the stall window, the bubble pattern, two
// frames in a row and a mid-frame reset.
// -----------------------------------------------------------------------------
module tb_del_map_fuse;

  localparam int PPB    = 4;
  localparam int DIM    = 8;
  localparam int LAT    = 3;
  localparam int DW     = 8 * PPB;
  localparam int BPF    = DIM * DIM / PPB;
  localparam int STAT_W = $clog2(DIM * DIM) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic [DW-1:0] old_map;
  logic [DW-1:0] new_map;
  logic [DW-1:0] del;
  logic          stall;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
`ifdef FUSE_STATS_EN
  logic [STAT_W-1:0] new_count;
  logic [STAT_W-1:0] last_count;
`endif

  always #5 clk = ~clk;

  del_map_fuse #(
    .PIXELS_PER_BEAT (PPB),
    .IMAGE_DIM       (DIM),
    .HSSIM_LATENCY   (LAT),
    .DATA_WIDTH      (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .old_map  (old_map),
    .new_map  (new_map),
    .del      (del),
    .stall    (stall),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
`ifdef FUSE_STATS_EN
    ,
    .new_count(new_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] old_b;
    logic [DW-1:0] new_b;
    logic [DW-1:0] del_b;
    logic [DW-1:0] exp_b;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  vec_t          tbl [BPF];
  exp_t          sbq [$];
  logic [DW-1:0] hs  [LAT];   // HSSIM stand-in: del pipeline

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int src_idx;
  int run_consumed;
  int stall_cycles;
  int first_out;
  logic          hold;
  logic          zero_del;
  logic          prev_stall;
  logic          prev_last;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] cur_del;
  logic [DW-1:0] cur_exp;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Present the next source beat unless the previous edge was stalled. On a
  // stall the source must hold its inputs.
  task automatic drive(input logic want_v, input logic rdy);
    m_tready = rdy;
    if (!hold) begin
      s_valid = want_v;
      old_map = tbl[src_idx % BPF].old_b;
      new_map = tbl[src_idx % BPF].new_b;
      cur_del = zero_del ? '0 : tbl[src_idx % BPF].del_b;
      cur_exp = zero_del ? tbl[src_idx % BPF].old_b : tbl[src_idx % BPF].exp_b;
    end
  endtask

  // One clock: monitor at negedge, then model the HSSIM/source advance at the
  // posedge, then present the new del a little after the edge.
  task automatic step();
    @(negedge clk);
    if (prev_stall) begin
      check("frozen_valid", m_tvalid, 1);
      check("frozen_data", m_tdata, prev_data);
      check("frozen_last", m_tlast, prev_last);
    end
    if (m_tvalid && m_tready) begin
      if (sbq.size() == 0) begin
        check("unexpected_beat", m_tdata, 'x);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("beat_data", m_tdata, e.data);
        check("beat_last", m_tlast, e.last);
`ifdef FUSE_STATS_EN
        if (m_tlast) last_count = new_count;
`endif
      end
    end
    if (m_tready) check("no_stall_when_ready", stall, 0);
    if (stall) stall_cycles++;
    if (m_tvalid && first_out < 0) first_out = cyc;
    prev_stall = stall;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    hold       = stall;
    @(posedge clk);
    if (!hold) begin
      for (int i = LAT - 1; i > 0; i--) hs[i] = hs[i-1];
      hs[0] = cur_del;
      if (s_valid) begin
        exp_t e;
        e.data = cur_exp;
        e.last = ((src_idx % BPF) == BPF - 1);
        sbq.push_back(e);
        src_idx++;
        run_consumed++;
      end
    end
    cyc++;
    #1 del = hs[LAT-1];
  endtask

  task automatic do_reset(input logic rdy);
    reset    = 1'b1;
    s_valid  = 1'b0;
    m_tready = rdy;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    hold       = 1'b0;
    prev_stall = 1'b0;
    src_idx    = 0;
    sbq.delete();
    del = hs[LAT-1];
  endtask

  // Stream n beats. alt: s_valid pattern 1,0,1,0. m_tready is low for lo_len
  // cycles starting at lo_start. zd: all-zero decisions.
  task automatic run_stream(input int n, input bit alt, input int lo_start, input int lo_len,
                            input bit zd, input bit chk_lat);
    int k;
    int start_cyc;
    bit vhist [512];
    k            = 0;
    zero_del     = zd;
    run_consumed = 0;
    stall_cycles = 0;
    first_out    = -1;
    start_cyc    = cyc;
    while ((run_consumed < n || sbq.size() > 0) && k < 400) begin
      drive((run_consumed < n) && (!alt || (k % 2 == 0)),
            !(k >= lo_start && k < lo_start + lo_len));
      vhist[k] = s_valid;
      // Without stalls, m_tvalid replays the s_valid pattern LAT+1 cycles later.
      if (alt && k >= LAT + 1) check("valid_mirror", m_tvalid, vhist[k-LAT-1]);
      step();
      k++;
    end
    s_valid = 1'b0;
    check("run_finished", k < 400, 1);
    check("all_beats_out", sbq.size(), 0);
    if (chk_lat) check("first_latency", first_out - start_cyc, LAT + 1);
  endtask

  initial begin
    // old, new, del, expected fused
    tbl[0]  = '{32'h11111111, 32'hEEEEEEEE, 32'hFF00FF00, 32'hEE11EE11};
    tbl[1]  = '{32'h01020304, 32'hA0B0C0D0, 32'hFF00FF00, 32'hA002C004};
    tbl[2]  = '{32'h11111111, 32'hEEEEEEEE, 32'h00000000, 32'h11111111};
    tbl[3]  = '{32'h11111111, 32'hEEEEEEEE, 32'hFFFFFFFF, 32'hEEEEEEEE};
    tbl[4]  = '{32'h12345678, 32'h9ABCDEF0, 32'h00FF00FF, 32'h12BC56F0};
    tbl[5]  = '{32'h12345678, 32'h9ABCDEF0, 32'h80007F01, 32'h9A345678};
    tbl[6]  = '{32'h00000000, 32'hFFFFFFFF, 32'hC0408001, 32'hFF00FF00};
    tbl[7]  = '{32'hAAAAAAAA, 32'h55555555, 32'hFF000000, 32'h55AAAAAA};
    tbl[8]  = '{32'hDEADBEEF, 32'h01234567, 32'h0000FFFF, 32'hDEAD4567};
    tbl[9]  = '{32'hCAFEF00D, 32'h13579BDF, 32'hFFFF0000, 32'h1357F00D};
    tbl[10] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00FFFF00, 32'h0FF0F00F};
    tbl[11] = '{32'h76543210, 32'hFEDCBA98, 32'hFF0000FF, 32'hFE543298};
    tbl[12] = '{32'h11223344, 32'h55667788, 32'h000000FF, 32'h11223388};
    tbl[13] = '{32'h99999999, 32'h66666666, 32'h80808080, 32'h66666666};
    tbl[14] = '{32'h13579BDF, 32'h2468ACE0, 32'h7F7F7F7F, 32'h13579BDF};
    tbl[15] = '{32'h0000FFFF, 32'hFFFF0000, 32'h00FF00FF, 32'h00FFFF00};

    for (int i = 0; i < LAT; i++) hs[i] = '0;
    old_map  = '0;
    new_map  = '0;
    del      = '0;
    cur_del  = '0;
    cur_exp  = '0;
    zero_del = 1'b0;
    s_valid  = 1'b0;
    m_tready = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // Reset state, with m_tready low so that stall is meaningful.
    check("rst_tvalid", m_tvalid, 0);
    check("rst_stall", stall, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tdata", m_tdata, 0);
`ifdef FUSE_STATS_EN
    check("rst_new_count", new_count, 0);
`endif

    // 1: back-to-back frame, always ready. Latency is LAT+1, and there is no stall.
    run_stream(16, 1'b0, 0, 0, 1'b0, 1'b1);
    check("t1_stall_cycles", stall_cycles, 0);

    // 2: m_tready low for 5 cycles mid-frame. Stall lasts exactly 5 cycles.
    run_stream(16, 1'b0, 8, 5, 1'b0, 1'b1);
    check("t2_stall_cycles", stall_cycles, 5);

    // 3: bubbles on the input. tlast must still fall on the 16th valid beat.
    run_stream(16, 1'b1, 0, 0, 1'b0, 1'b1);

    // 4: two frames back to back. tlast on beats 15 and 31.
    run_stream(32, 1'b0, 0, 0, 1'b0, 1'b1);

    // 5: reset mid-frame, with a held output beat and beats in flight.
    zero_del = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0);
      step();
    end
    check("t5_held_valid", m_tvalid, 1);
    check("t5_held_stall", stall, 1);
    do_reset(1'b0);
    check("t5_rst_tvalid", m_tvalid, 0);
    check("t5_rst_stall", stall, 0);
    check("t5_rst_tlast", m_tlast, 0);
    check("t5_rst_tdata", m_tdata, 0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1);
      step();
    end
    check("t5_flushed", m_tvalid, 0);
    run_stream(16, 1'b0, 0, 0, 1'b0, 1'b1);

`ifdef FUSE_STATS_EN
    // 6: the table frame selects 29 new pixels. An all-zero frame selects 0.
    run_stream(16, 1'b0, 0, 0, 1'b0, 1'b0);
    check("t6_count_table", last_count, 29);
    run_stream(16, 1'b0, 0, 0, 1'b1, 1'b0);
    check("t6_count_zero", last_count, 0);
    check("t6_count_hold", new_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
